psum_requant_acc: RTL and testbench

- Sits directly downstream of the 3x3 adder tree.
- Consumes its registered 32-bit partial sums over a valid/ready handshake and accumulates one psum per input channel on top of a per-output-channel bias.
- After the last channel, requantizes the sum with a rounding right shift, optional ReLU and int8 saturation, then presents one output pixel at a time to the output buffer.
- Counts pixels per tile and signals completion.

---
 rtl/psum_requant_acc.sv | 172 +++++++++++++++++
 tb/tb_psum_requant_acc.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_requant_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : psum_requant_acc
//  Purpose  : Accumulates per-channel psums on a bias, then requantizes to
//             int8 (round-half-up shift, optional ReLU, saturation).
//  Revision : 1.0
// ============================================================================
module psum_requant_acc #(
    parameter int PSUM_W = 32,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic [CNT_W-1:0]         cfg_num_ch,
    input  logic [CNT_W-1:0]         cfg_num_px,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic signed [ACC_W-1:0]  cfg_bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PSUM_W-1:0] psum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_POST = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic signed [ACC_W:0] c_out_max =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_out_min = ~c_out_max;
    localparam logic [CNT_W-1:0]      c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                   r_state;
    logic [CNT_W-1:0]         r_num_ch;
    logic [CNT_W-1:0]         r_num_px;
    logic [CNT_W-1:0]         r_ch_cnt;
    logic [CNT_W-1:0]         r_px_cnt;
    logic [4:0]               r_shift;
    logic                     r_relu;
    logic signed [ACC_W-1:0]  r_bias;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;
    logic                     r_done;
    logic signed [OUT_W-1:0]  r_out_data;

    logic signed [ACC_W-1:0]  w_psum_ext;
    logic signed [ACC_W:0]    w_rnd;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W:0]    w_shifted;
    logic signed [OUT_W-1:0]  w_quant;
    logic                     w_accept;
    logic                     w_last_ch;
    logic                     w_last_px;

    assign w_psum_ext = ACC_W'(psum_in);
    assign w_accept   = in_valid & r_in_ready;
    assign w_last_ch  = (r_ch_cnt == r_num_ch - c_cnt_one);
    assign w_last_px  = (r_px_cnt == r_num_px - c_cnt_one);

    // One extra bit of headroom keeps the rounding offset from wrapping.
    always_comb begin
        w_rnd = '0;
        if (r_shift != 5'd0) begin
            w_rnd = {{ACC_W{1'b0}}, 1'b1} << (r_shift - 5'd1);
        end
        w_sum     = {r_acc[ACC_W-1], r_acc} + w_rnd;
        w_shifted = w_sum >>> r_shift;
        if (r_relu && (w_shifted < 0)) begin
            w_quant = '0;
        end else if (w_shifted > c_out_max) begin
            w_quant = c_out_max[OUT_W-1:0];
        end else if (w_shifted < c_out_min) begin
            w_quant = c_out_min[OUT_W-1:0];
        end else begin
            w_quant = w_shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num_ch    <= c_cnt_one;
            r_num_px    <= c_cnt_one;
            r_ch_cnt    <= '0;
            r_px_cnt    <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_bias      <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_num_ch   <= (cfg_num_ch == '0) ? c_cnt_one : cfg_num_ch;
                        r_num_px   <= (cfg_num_px == '0) ? c_cnt_one : cfg_num_px;
                        r_shift    <= cfg_shift;
                        r_relu     <= cfg_relu;
                        r_bias     <= cfg_bias;
                        r_acc      <= cfg_bias;
                        r_ch_cnt   <= '0;
                        r_px_cnt   <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_psum_ext;
                        if (w_last_ch) begin
                            r_ch_cnt   <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_POST;
                        end else begin
                            r_ch_cnt <= r_ch_cnt + c_cnt_one;
                        end
                    end
                end
                S_POST: begin
                    r_out_data  <= w_quant;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_px) begin
                            r_px_cnt <= '0;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_px_cnt   <= r_px_cnt + c_cnt_one;
                            r_acc      <= r_bias;
                            r_in_ready <= 1'b1;
                            r_state    <= S_ACC;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_psum_requant_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_psum_requant_acc
//  Purpose  : Self-checking bench for psum_requant_acc against an arithmetic
//             reference model.
//  Revision : 1.0
// ============================================================================
module tb_psum_requant_acc;

    localparam int PSUM_W = 32;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 10;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     cfg_start = 1'b0;
    logic [CNT_W-1:0]         cfg_num_ch = '0;
    logic [CNT_W-1:0]         cfg_num_px = '0;
    logic [4:0]               cfg_shift = '0;
    logic                     cfg_relu = 1'b0;
    logic signed [ACC_W-1:0]  cfg_bias = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [PSUM_W-1:0] psum_in = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [OUT_W-1:0]  out_data;
    logic                     busy;
    logic                     done;

    psum_requant_acc #(
        .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_ch(cfg_num_ch),
        .cfg_num_px(cfg_num_px), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .cfg_bias(cfg_bias), .in_valid(in_valid), .in_ready(in_ready),
        .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [31:0] stim[$];
    logic signed [7:0]  got_data[$];
    int                 got_cyc[$];
    int                 consumed;
    int                 done_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: wrapped sum, floor((s + half) / 2^sh), ReLU, int8 clamp.
    function automatic logic signed [7:0] ref_out(input int bias, input int px,
                                                  input int nch, input int sh,
                                                  input bit relu);
        longint s, d, q;
        s = longint'(bias);
        for (int i = 0; i < nch; i++) s += longint'(stim[px*nch + i]);
        s = longint'(int'(s));
        if (sh > 0) s += longint'(1) << (sh - 1);
        d = longint'(1) << sh;
        q = s / d;
        if ((s % d) != 0 && s < 0) q -= 1;
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    task automatic start_tile(input int nch, input int npx, input int sh,
                              input bit relu, input int bias);
        cfg_num_ch = CNT_W'(nch);
        cfg_num_px = CNT_W'(npx);
        cfg_shift  = 5'(sh);
        cfg_relu   = relu;
        cfg_bias   = bias;
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
        // Scramble config afterwards; the latched copy must be used.
        cfg_num_ch = CNT_W'($urandom);
        cfg_num_px = CNT_W'($urandom);
        cfg_shift  = 5'($urandom);
        cfg_relu   = 1'($urandom);
        cfg_bias   = $urandom;
    endtask

    task automatic send_psum(input logic signed [31:0] v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        psum_in  = v;
        for (int k = 0; k < 50; k++) begin
            if (in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        psum_in  = '0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_psum_timeout: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic wait_out();
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_out_timeout: out_valid=%b, required 1", out_valid);
        end
    endtask

    task automatic handshake_and_finish();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    task automatic one_shot(input int bias, input int sh, input bit relu,
                            input logic signed [31:0] p,
                            output logic signed [7:0] d);
        start_tile(1, 1, sh, relu, bias);
        send_psum(p);
        wait_out();
        d = out_data;
        handshake_and_finish();
    endtask

    task automatic run_stream(input bit rv, input bit rr, input int budget);
        int cyc = 0;
        int idx = 0;
        got_data.delete();
        got_cyc.delete();
        done_seen = 0;
        while (cyc < budget) begin
            in_valid  = (idx < stim.size()) && (!rv || $urandom_range(0, 2) != 0);
            psum_in   = (idx < stim.size()) ? stim[idx] : '0;
            out_ready = !rr || ($urandom_range(0, 1) == 1);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            tick();
            cyc++;
            if (done) begin
                done_seen++;
                break;
            end
        end
        consumed  = idx;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got {in_ready,out_valid,busy,done}=%b, required 0000",
                     {in_ready, out_valid, busy, done});
        end
        n_checks++;
        if (out_data !== 8'sd0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %0d, required 0", out_data);
        end
    endtask

    task automatic test_basic();
        start_tile(3, 1, 2, 1'b0, 0);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start: in_ready=%b busy=%b, required 1 1", in_ready, busy);
        end
        send_psum(10);
        send_psum(20);
        send_psum(30);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_post_cycle: out_valid=%b in_ready=%b, required 0 0",
                     out_valid, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: out_valid=%b, required 1", out_valid);
        end
        n_checks++;
        if (out_data !== 8'sd15) begin
            n_fail++;
            $display("FAIL basic_data: got %0d, required 15", out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b busy=%b out_valid=%b, required 1 0 0",
                     done, busy, out_valid);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_width: done=%b, required 0", done);
        end
    endtask

    task automatic test_rounding();
        logic signed [7:0] d;
        one_shot(0, 1, 1'b0, -3, d);
        n_checks++;
        if (d !== -8'sd1) begin n_fail++; $display("FAIL round_neg: got %0d, required -1", d); end
        one_shot(0, 1, 1'b0, 3, d);
        n_checks++;
        if (d !== 8'sd2) begin n_fail++; $display("FAIL round_pos: got %0d, required 2", d); end
        one_shot(0, 0, 1'b0, 5, d);
        n_checks++;
        if (d !== 8'sd5) begin n_fail++; $display("FAIL round_shift0: got %0d, required 5", d); end
    endtask

    task automatic test_saturation_relu();
        logic signed [7:0] d;
        one_shot(1000, 0, 1'b0, 0, d);
        n_checks++;
        if (d !== 8'sd127) begin n_fail++; $display("FAIL sat_pos: got %0d, required 127", d); end
        one_shot(0, 0, 1'b0, -2000, d);
        n_checks++;
        if (d !== -8'sd128) begin n_fail++; $display("FAIL sat_neg: got %0d, required -128", d); end
        one_shot(0, 0, 1'b1, -2000, d);
        n_checks++;
        if (d !== 8'sd0) begin n_fail++; $display("FAIL relu: got %0d, required 0", d); end
    endtask

    task automatic test_backpressure();
        logic signed [7:0] first;
        start_tile(2, 2, 0, 1'b0, 50);
        send_psum(10);
        send_psum(-5);
        wait_out();
        first = out_data;
        n_checks++;
        if (first !== 8'sd55) begin n_fail++; $display("FAIL bp_first: got %0d, required 55", first); end
        in_valid = 1'b1;
        psum_in  = 777;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== first || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall: out_valid=%b out_data=%0d in_ready=%b, required 1 %0d 0",
                         out_valid, out_data, in_ready, first);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_psum(3);
        send_psum(4);
        wait_out();
        n_checks++;
        if (out_data !== 8'sd57) begin n_fail++; $display("FAIL bp_second_from_bias: got %0d, required 57", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: done=%b, required 1", done); end
        tick();
    endtask

    task automatic test_zero_counts();
        stim = '{9};
        start_tile(0, 0, 0, 1'b0, 4);
        run_stream(1'b0, 1'b0, 50);
        n_checks++;
        if (got_data.size() != 1 || done_seen != 1 || consumed != 1) begin
            n_fail++;
            $display("FAIL zero_counts: outputs=%0d done=%0d consumed=%0d, required 1 1 1",
                     got_data.size(), done_seen, consumed);
        end else begin
            n_checks++;
            if (got_data[0] !== 8'sd13) begin n_fail++; $display("FAIL zero_counts_data: got %0d, required 13", got_data[0]); end
        end
        tick();
    endtask

    task automatic test_bubbles();
        start_tile(2, 1, 0, 1'b0, 3);
        in_valid = 1'b1; psum_in = 40;  tick();
        in_valid = 1'b0; psum_in = 999; tick();
        in_valid = 1'b1; psum_in = -11; tick();
        in_valid = 1'b0; psum_in = 999;
        wait_out();
        n_checks++;
        if (out_data !== 8'sd32) begin n_fail++; $display("FAIL bubbles: got %0d, required 32", out_data); end
        handshake_and_finish();
    endtask

    task automatic test_start_while_busy();
        start_tile(2, 1, 1, 1'b0, 5);
        send_psum(20);
        cfg_num_ch = 1; cfg_num_px = 1; cfg_shift = 0; cfg_bias = 1000; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_state: in_ready=%b busy=%b, required 1 1", in_ready, busy);
        end
        send_psum(30);
        wait_out();
        n_checks++;
        if (out_data !== 8'sd28) begin n_fail++; $display("FAIL busy_start_data: got %0d, required 28", out_data); end
        handshake_and_finish();
    endtask

    task automatic test_reset_mid_tile();
        bit saw_done = 1'b0;
        start_tile(3, 1, 0, 1'b0, 7);
        send_psum(100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, in_ready, out_valid, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: got {busy,in_ready,out_valid,done}=%b, required 0000",
                     {busy, in_ready, out_valid, done});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin n_fail++; $display("FAIL rst_mid_done: saw done=1, required 0"); end
        stim = '{1, 2, 3};
        start_tile(3, 1, 0, 1'b0, 7);
        run_stream(1'b0, 1'b0, 50);
        n_checks++;
        if (got_data.size() != 1 || consumed != 3 || done_seen != 1) begin
            n_fail++;
            $display("FAIL rst_mid_rerun: outputs=%0d consumed=%0d done=%0d, required 1 3 1",
                     got_data.size(), consumed, done_seen);
        end else begin
            n_checks++;
            if (got_data[0] !== 8'sd13) begin n_fail++; $display("FAIL rst_mid_data: got %0d, required 13", got_data[0]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int nch = 3, npx = 4, sh = 4, bias = -20;
        stim.delete();
        for (int i = 0; i < nch*npx; i++) stim.push_back($signed($urandom_range(0, 800)) - 400);
        start_tile(nch, npx, sh, 1'b0, bias);
        run_stream(1'b0, 1'b0, 200);
        n_checks++;
        if (got_data.size() != npx || done_seen != 1 || consumed != nch*npx) begin
            n_fail++;
            $display("FAIL b2b_count: outputs=%0d done=%0d consumed=%0d, required %0d 1 %0d",
                     got_data.size(), done_seen, consumed, npx, nch*npx);
        end else begin
            for (int p = 0; p < npx; p++) begin
                n_checks++;
                if (got_data[p] !== ref_out(bias, p, nch, sh, 1'b0)) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %0d, required %0d", p, got_data[p],
                             ref_out(bias, p, nch, sh, 1'b0));
                end
                if (p > 0) begin
                    n_checks++;
                    if (got_cyc[p] - got_cyc[p-1] != nch + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles, required %0d", p,
                                 got_cyc[p] - got_cyc[p-1], nch + 2);
                    end
                end
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            int  nch  = $urandom_range(1, 5);
            int  npx  = $urandom_range(1, 4);
            int  sh   = $urandom_range(0, 31);
            bit  relu = 1'($urandom);
            int  bias = $signed($urandom) >>> $urandom_range(0, 31);
            stim.delete();
            for (int i = 0; i < nch*npx; i++)
                stim.push_back($signed($urandom) >>> $urandom_range(0, 31));
            start_tile(nch, npx, sh, relu, bias);
            run_stream(1'b1, 1'b1, 2000);
            n_checks++;
            if (got_data.size() != npx || done_seen != 1) begin
                n_fail++;
                $display("FAIL rand_count[%0d]: outputs=%0d done=%0d, required %0d 1",
                         t, got_data.size(), done_seen, npx);
            end else begin
                for (int p = 0; p < npx; p++) begin
                    n_checks++;
                    if (got_data[p] !== ref_out(bias, p, nch, sh, relu)) begin
                        n_fail++;
                        $display("FAIL rand_data[%0d][%0d]: got %0d, required %0d", t, p,
                                 got_data[p], ref_out(bias, p, nch, sh, relu));
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation_relu();
        test_backpressure();
        test_zero_counts();
        test_bubbles();
        test_start_while_busy();
        test_reset_mid_tile();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
